// File: rtl/scaler_gate_counter_if.sv
// Readout port of the gate scaler: channel select, registered count/saturation,
// and the snapshot valid/ack handshake with its sticky overwrite flag.
interface scaler_gate_counter_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 2
);
  logic [SELW-1:0]  sel_i;
  logic [WIDTH-1:0] dat_o;
  logic             sat_o;
  logic             valid_o;
  logic             ack_i;
  logic             lost_o;

  // master is the register-interface side that selects channels and acknowledges snapshots
  modport master (output sel_i, ack_i, input dat_o, sat_o, valid_o, lost_o);
  modport slave  (input sel_i, ack_i, output dat_o, sat_o, valid_o, lost_o);
endinterface

// File: rtl/scaler_gate_counter.sv
// Multi-channel rate scaler: counts rising edges per channel over a gate of
// PERIOD_TICKS kHz ticks, snapshots all channels at once, serves them via rd.
module scaler_gate_counter #(
  parameter int NCH          = 4,
  parameter int WIDTH        = 16,
  parameter int PERIOD_TICKS = 1000,
  parameter int SELW         = 2
) (
  input  logic                   clk33_i,
  input  logic                   rst_n_i,
  input  logic                   khz_tick_i,
  input  logic                   enable_i,
  input  logic [NCH-1:0]         scal_i,
  scaler_gate_counter_if.slave   rd
);

  localparam int               TW      = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

  state_t            state, state_next;
  logic [NCH-1:0]    prev;
  logic [NCH-1:0]    edges;
  logic [WIDTH-1:0]  live    [NCH];
  logic [WIDTH-1:0]  latched [NCH];
  logic [NCH-1:0]    sat_flag;
  logic [TW-1:0]     tick_cnt;
  logic [SELW-1:0]   sel;
  logic              clear_live, count_en, do_latch;
  logic              gate_end, ack_take;

  assign edges    = scal_i & ~prev;
  assign gate_end = count_en & khz_tick_i & (tick_cnt == TW'(PERIOD_TICKS - 1));
  assign ack_take = rd.valid_o & rd.ack_i;
  assign sel      = rd.sel_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (enable_i) state_next = COUNT;
      COUNT:   if (!enable_i)    state_next = IDLE;
               else if (gate_end) state_next = LATCH;
      LATCH:   state_next = enable_i ? COUNT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clear_live = 1'b0;
    count_en   = 1'b0;
    do_latch   = 1'b0;
    case (state)
      IDLE:    clear_live = 1'b1;
      COUNT:   count_en   = 1'b1;
      LATCH:   do_latch   = 1'b1;
      default: clear_live = 1'b1;
    endcase
  end

  // ------------------------------------------------------- edge history
  // All-ones at reset so inputs already high at release are not counted.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) prev <= '1;
    else          prev <= scal_i;
  end

  // ------------------------------------------------ live counters, ticks
  // The gate-end edge is folded into live during COUNT, so LATCH copies live
  // as-is while the new gate already starts with the LATCH-cycle edge.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NCH; n++) live[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (clear_live)
          live[n] <= '0;
        else if (do_latch)
          live[n] <= WIDTH'(edges[n]);
        else if (count_en && edges[n] && (live[n] != CNT_MAX))
          live[n] <= live[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i)                  tick_cnt <= '0;
    else if (clear_live)           tick_cnt <= '0;
    else if (do_latch)             tick_cnt <= TW'(khz_tick_i);
    else if (gate_end)             tick_cnt <= '0;
    else if (count_en && khz_tick_i) tick_cnt <= tick_cnt + 1'b1;
  end

  // ------------------------------------------------------------ snapshot
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the snapshot array is reset explicitly; readout after reset must return 0, not stale data.
      for (int n = 0; n < NCH; n++) latched[n] <= '0;
      sat_flag <= '0;
    end else if (do_latch) begin
      for (int n = 0; n < NCH; n++) begin
        latched[n]  <= live[n];
        sat_flag[n] <= (live[n] == CNT_MAX);
      end
    end
  end

  // ----------------------------------------------------------- handshake
  // A latch coinciding with an ack hands the ack to the old snapshot, so no loss.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd.valid_o <= 1'b0;
      rd.lost_o  <= 1'b0;
    end else if (do_latch) begin
      rd.valid_o <= 1'b1;
      if (rd.valid_o && !rd.ack_i) rd.lost_o <= 1'b1;
      else if (ack_take)           rd.lost_o <= 1'b0;
    end else if (ack_take) begin
      rd.valid_o <= 1'b0;
      rd.lost_o  <= 1'b0;
    end
  end

  // ------------------------------------------------------------- readout
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd.dat_o <= '0;
      rd.sat_o <= 1'b0;
    end else if (int'(sel) < NCH) begin
      rd.dat_o <= latched[sel];
      rd.sat_o <= sat_flag[sel];
    end else begin
      rd.dat_o <= '0;
      rd.sat_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scaler_gate_counter.sv
// Bench for scaler_gate_counter: a 16-bit and a 4-bit instance share stimulus and
// are compared every cycle against an integer-count reference model.
module tb_scaler_gate_counter;

  localparam int NCH  = 4;
  localparam int P    = 4;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            khz_tick;
  logic            enable;
  logic [NCH-1:0]  scal;
  logic [SELW-1:0] sel;
  logic            ack;

  always #15 clk = ~clk;

  scaler_gate_counter_if #(.WIDTH(16), .SELW(SELW)) bus16 ();
  scaler_gate_counter_if #(.WIDTH(4),  .SELW(SELW)) bus4  ();

  assign bus16.sel_i = sel;
  assign bus16.ack_i = ack;
  assign bus4.sel_i  = sel;
  assign bus4.ack_i  = ack;

  scaler_gate_counter #(.NCH(NCH), .WIDTH(16), .PERIOD_TICKS(P), .SELW(SELW)) dut16 (
    .clk33_i(clk), .rst_n_i(rst_n), .khz_tick_i(khz_tick), .enable_i(enable),
    .scal_i(scal), .rd(bus16)
  );

  scaler_gate_counter #(.NCH(NCH), .WIDTH(4), .PERIOD_TICKS(P), .SELW(SELW)) dut4 (
    .clk33_i(clk), .rst_n_i(rst_n), .khz_tick_i(khz_tick), .enable_i(enable),
    .scal_i(scal), .rd(bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------- model
  // Channels are counted as unbounded integers; saturation is applied only
  // when a snapshot is read, as min(count, 2^W-1).
  int             m_cnt  [NCH];
  int             m_pend [NCH];
  int             m_snap [NCH];
  int             m_ticks;
  bit             m_active, m_latch, m_valid, m_lost;
  logic [NCH-1:0] m_prev;
  int             e_dat16, e_dat4;
  bit             e_sat16, e_sat4;

  function automatic int clamp(input int c, input int w);
    int mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin m_cnt[n] = 0; m_pend[n] = 0; m_snap[n] = 0; end
    m_ticks = 0; m_active = 0; m_latch = 0; m_valid = 0; m_lost = 0;
    m_prev  = '1;
    e_dat16 = 0; e_dat4 = 0; e_sat16 = 0; e_sat4 = 0;
  endtask

  task automatic clear_gate();
    for (int n = 0; n < NCH; n++) m_cnt[n] = 0;
    m_ticks = 0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] edges;
    bit take;
    edges = scal & ~m_prev;
    if (int'(sel) < NCH) begin
      e_dat16 = clamp(m_snap[sel], 16); e_sat16 = (m_snap[sel] >= 65535);
      e_dat4  = clamp(m_snap[sel], 4);  e_sat4  = (m_snap[sel] >= 15);
    end else begin
      e_dat16 = 0; e_sat16 = 0; e_dat4 = 0; e_sat4 = 0;
    end
    take = m_valid && ack;
    if (m_latch) begin
      m_snap = m_pend;
      if (m_valid && !ack) m_lost = 1;
      else if (take)       m_lost = 0;
      m_valid  = 1;
      m_latch  = 0;
      m_active = enable;
      if (enable) begin
        for (int n = 0; n < NCH; n++) m_cnt[n] = int'(edges[n]);
        m_ticks = int'(khz_tick);
      end else clear_gate();
    end else begin
      if (take) begin m_valid = 0; m_lost = 0; end
      if (m_active && !enable) begin
        m_active = 0; clear_gate();
      end else if (m_active) begin
        for (int n = 0; n < NCH; n++) m_cnt[n] += int'(edges[n]);
        if (khz_tick) begin
          m_ticks++;
          if (m_ticks == P) begin m_pend = m_cnt; m_latch = 1; end
        end
      end else begin
        clear_gate();
        m_active = enable;
      end
    end
    m_prev = scal;
  endtask

  // ----------------------------------------------------------- drivers
  bit auto_tick  = 0;
  int tick_phase = 0;

  task automatic compare_all();
    check("valid16", bus16.valid_o, m_valid);
    check("lost16",  bus16.lost_o,  m_lost);
    check("dat16",   bus16.dat_o,   e_dat16);
    check("sat16",   bus16.sat_o,   e_sat16);
    check("valid4",  bus4.valid_o,  m_valid);
    check("lost4",   bus4.lost_o,   m_lost);
    check("dat4",    bus4.dat_o,    e_dat4);
    check("sat4",    bus4.sat_o,    e_sat4);
  endtask

  task automatic cycle();
    if (auto_tick) khz_tick = (tick_phase == 32);
    model_step();
    @(posedge clk); #1;
    tick_phase = (tick_phase + 1) % 33;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 0; enable = 0; khz_tick = 0; scal = '0; ack = 0; sel = '0;
    auto_tick = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic read(input int s);
    sel = s[SELW-1:0];
    cycle();
  endtask

  task automatic do_ack();
    ack = 1; cycle(); ack = 0;
  endtask

  // Pulses per channel, then P ticks each followed by a quiet cycle; the last quiet cycle is LATCH.
  task automatic gate(input int p0, input int p1, input int p2, input int p3, input bit ack_latch);
    int pc[NCH];
    int mx;
    pc = '{p0, p1, p2, p3};
    mx = 0;
    for (int n = 0; n < NCH; n++) if (pc[n] > mx) mx = pc[n];
    for (int k = 0; k < mx; k++) begin
      for (int n = 0; n < NCH; n++) scal[n] = (k < pc[n]);
      cycle();
      scal = '0;
      cycle();
    end
    for (int t = 0; t < P; t++) begin
      khz_tick = 1; cycle();
      khz_tick = 0;
      if (t == P - 1 && ack_latch) ack = 1;
      cycle();
      ack = 0;
    end
  endtask

  task automatic single_tick();
    khz_tick = 1; cycle(); khz_tick = 0; cycle();
  endtask

  typedef struct {
    int sel;
    int dat;
    bit sat;
  } rd_vec_t;

  rd_vec_t tbl [4];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{sel: 0, dat: 10, sat: 1'b0};
    tbl[1] = '{sel: 1, dat: 0,  sat: 1'b0};
    tbl[2] = '{sel: 2, dat: 3,  sat: 1'b0};
    tbl[3] = '{sel: 3, dat: 0,  sat: 1'b0};

    // ---- reset state and basic gate with periodic ticks
    do_reset();
    check("rst_valid", bus16.valid_o, 0);
    check("rst_lost",  bus16.lost_o,  0);
    check("rst_dat",   bus16.dat_o,   0);
    check("rst_sat",   bus16.sat_o,   0);
    auto_tick = 1; tick_phase = 0; enable = 1;
    for (int c = 0; c < 200; c++) begin
      scal = '0;
      if (c >= 2  && (c - 2)  % 11 == 0 && (c - 2)  / 11 < 10) scal[0] = 1;
      if (c >= 10 && (c - 10) % 30 == 0 && (c - 10) / 30 < 3)  scal[2] = 1;
      cycle();
      if (bus16.valid_o) break;
    end
    scal = '0;
    check("gate1_valid", bus16.valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      read(tbl[i].sel);
      check("tbl_dat16", bus16.dat_o, tbl[i].dat);
      check("tbl_sat16", bus16.sat_o, tbl[i].sat);
      check("tbl_dat4",  bus4.dat_o,  tbl[i].dat);
    end
    do_ack();
    check("ack_valid", bus16.valid_o, 0);
    auto_tick = 0; khz_tick = 0;

    // ---- edges on the gate-end cycle and on the LATCH cycle; LATCH tick is tick 1
    do_reset();
    enable = 1; cycle(); cycle();
    for (int t = 0; t < P - 1; t++) begin khz_tick = 1; cycle(); khz_tick = 0; repeat (3) cycle(); end
    khz_tick = 1; scal = 4'b0010; cycle();
    khz_tick = 1; scal = 4'b1010; cycle();
    khz_tick = 0; scal = '0;
    check("bnd_valid", bus16.valid_o, 1);
    read(1); check("bnd_n_ch1", bus16.dat_o, 1);
    read(3); check("bnd_n_ch3", bus16.dat_o, 0);
    do_ack();
    single_tick(); single_tick();
    check("bnd_no_early", bus16.valid_o, 0);
    khz_tick = 1; cycle(); khz_tick = 0; cycle();
    check("bnd_valid2", bus16.valid_o, 1);
    read(3); check("bnd_n1_ch3", bus16.dat_o, 1);
    read(1); check("bnd_n1_ch1", bus16.dat_o, 0);
    check("bnd_lost", bus16.lost_o, 0);

    // ---- saturation on the 4-bit instance
    do_reset();
    enable = 1; cycle();
    gate(0, 0, 0, 20, 0);
    read(3);
    check("sat_dat4",  bus4.dat_o,  15);
    check("sat_sat4",  bus4.sat_o,  1);
    check("sat_dat16", bus16.dat_o, 20);
    check("sat_sat16", bus16.sat_o, 0);
    do_ack();
    gate(0, 0, 0, 2, 0);
    read(3);
    check("unsat_dat4", bus4.dat_o, 2);
    check("unsat_sat4", bus4.sat_o, 0);

    // ---- overwrite without ack, then ack on the LATCH cycle
    do_reset();
    enable = 1; cycle();
    gate(3, 0, 0, 0, 0);
    check("ovr_lost0", bus16.lost_o, 0);
    gate(5, 0, 0, 0, 0);
    check("ovr_lost1",  bus16.lost_o,  1);
    check("ovr_valid1", bus16.valid_o, 1);
    read(0); check("ovr_dat", bus16.dat_o, 5);
    do_ack();
    check("ovr_ack_valid", bus16.valid_o, 0);
    check("ovr_ack_lost",  bus16.lost_o,  0);
    gate(1, 0, 0, 0, 0);
    gate(2, 0, 0, 0, 1);
    check("same_valid", bus16.valid_o, 1);
    check("same_lost",  bus16.lost_o,  0);
    read(0); check("same_dat", bus16.dat_o, 2);

    // ---- enable dropped mid-gate discards the partial gate
    do_reset();
    enable = 1; cycle();
    single_tick(); single_tick();
    for (int k = 0; k < 5; k++) begin scal[2] = 1; cycle(); scal[2] = 0; cycle(); end
    enable = 0; repeat (3) cycle();
    check("dis_valid", bus16.valid_o, 0);
    enable = 1; cycle();
    single_tick(); single_tick(); single_tick();
    check("dis_no_early", bus16.valid_o, 0);
    gate(0, 0, 1, 0, 0);
    check("dis_valid2", bus16.valid_o, 1);
    read(2); check("dis_dat", bus16.dat_o, 1);

    // ---- asynchronous reset mid-gate; high inputs at release do not count
    do_reset();
    enable = 1; cycle();
    gate(2, 0, 0, 0, 0);
    read(0); check("pre_rst_dat", bus16.dat_o, 2);
    single_tick();
    #5 rst_n = 0; scal = '1; model_reset();
    #1;
    check("arst_valid", bus16.valid_o, 0);
    check("arst_dat",   bus16.dat_o,   0);
    check("arst_lost",  bus16.lost_o,  0);
    check("arst_valid4", bus4.valid_o, 0);
    @(posedge clk); #1 rst_n = 1;
    cycle();
    for (int t = 0; t < P; t++) single_tick();
    check("rel_valid", bus16.valid_o, 1);
    for (int s = 0; s < NCH; s++) begin
      read(s); check("rel_dat", bus16.dat_o, 0);
    end
    scal = '0;

    // ---- randomized traffic against the model
    do_reset();
    enable = 1;
    for (int c = 0; c < 3000; c++) begin
      khz_tick = ($urandom_range(0, 7) == 0);
      scal     = NCH'($urandom);
      ack      = ($urandom_range(0, 9) == 0);
      sel      = SELW'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
